brainhack_core_p: RTL and testbench
===================================

Name: brainhack_core_p

Overview:
- Parametrised next-generation brainhack execution core: fetches 3-bit instructions from program ROM, operates on tape RAM, and keeps loop return addresses in a stack RAM.
- Adds over the current core: parametrised widths/depths, ready/valid byte I/O for '.' and ',', forward-skip of zero-entry loops, a halt point, and error detection.
- Sits between the tape ram, stack ram and prgmem rom instances in the top level.

Parameters:
- TAPE_AW, 8, tape address width; the tape pointer wraps modulo 2^TAPE_AW.
- TAPE_DW, 8, tape cell width; also the I/O data width.
- PRG_AW, 8, program address width.
- STACK_AW, 4, loop stack address width; depth is 2^STACK_AW.
- PRG_END, 2^PRG_AW-1, halt address; fetching from it halts the core.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- i_tape_data  in  TAPE_DW  tape read data (combinational from o_tape_addr).
- i_prgmem_data  in  3  instruction at o_prgmem_addr (combinational).
- i_stack_data  in  PRG_AW  stack read data at o_stack_addr (combinational).
- o_tape_in  out  1  tape write enable, sampled on clock.
- o_tape_addr  out  TAPE_AW  tape pointer TP.
- o_tape_data  out  TAPE_DW  tape write data.
- o_prgmem_addr  out  PRG_AW  program counter PC.
- o_stack_in  out  1  stack write enable.
- o_stack_addr  out  STACK_AW  SP on push, otherwise SP-1.
- o_stack_data  out  PRG_AW  push data.
- o_out_valid  out  1  output byte valid.
- o_out_data  out  TAPE_DW  output byte.
- i_out_ready  in  1  sink accepts.
- i_in_valid  in  1  input byte valid.
- i_in_data  in  TAPE_DW  input byte.
- o_in_ready  out  1  core accepts input.
- o_halted  out  1  normal termination.
- o_error  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 unmatched '['.

Behaviour:
- Encoding: 000 '+', 001 '-', 010 '>', 011 '<', 100 '.', 101 ',', 110 '[', 111 ']'.
- Reset (async, reset_n=0):
  - PC=0, TP=0, SP=0, IR=0, depth=0, state FETCH.
  - All enables, valids and o_in_ready are 0; o_halted=0, o_error=00.
  - Tape and stack contents are not cleared.
  - Reset mid-operation aborts any handshake immediately.
- FETCH:
  - If PC==PRG_END: go to HALT.
  - Otherwise latch IR=i_prgmem_data and go to EXEC.
  - Each plain instruction therefore takes 2 cycles.
- EXEC:
  - '+'/'-': o_tape_in=1, o_tape_data=i_tape_data±1 (wraps modulo 2^TAPE_DW); PC+1.
  - '>'/'<': TP±1 (wraps modulo 2^TAPE_AW); PC+1.
  - '.': go to OUT. In OUT, o_out_valid=1 and o_out_data=i_tape_data. On the cycle with i_out_ready=1, transfer, then PC+1 and FETCH. o_out_valid stays high and the data stays stable until the transfer.
  - ',': go to IN. In IN, o_in_ready=1. On the cycle with i_in_valid=1, write i_in_data to tape[TP], then PC+1 and FETCH.
  - '[' with cell≠0:
    - SP==2^STACK_AW: ERROR 01.
    - Otherwise push PC+1 (o_stack_in=1, addr=SP), SP+1, PC+1.
  - '[' with cell==0: depth=1, PC+1, go to SKIP.
  - ']' with cell≠0:
    - SP==0: ERROR 10.
    - Otherwise PC=i_stack_data (top of stack, no pop).
  - ']' with cell==0:
    - SP==0: ERROR 10.
    - Otherwise pop (SP-1), PC+1.
- SKIP (1 instruction/cycle, no tape access):
  - PC==PRG_END: ERROR 11.
  - '[': depth+1.
  - ']': depth-1; if depth reaches 0, PC+1 and go to FETCH.
  - Otherwise PC+1.
  - The depth counter is PRG_AW bits wide.
- HALT: o_halted=1; state held until reset.
- ERROR: o_error holds the code, o_halted=0; state held until reset; PC, TP and SP are frozen.
- SP is STACK_AW+1 bits wide so that full is detectable.

Optional Feature:
- Macro: BRAINHACK_CELL_SAT_EN.
- Defined: '+' at all-ones and '-' at zero leave the cell unchanged (saturating); no write is issued.
- Undefined: modular wrap as above.

Decomposition:
- Shared package/header `brainhack_defs`: opcode constants, state encoding, error codes, default widths.
- One sub-module, brainhack_io_port: the OUT/IN handshake holding registers, so they can be reused by the debug bridge.

Test Plan:
- Program "+++." with PRG_END=4: cell 0 = 3; o_out_data=3 held through 5 cycles of i_out_ready=0; o_halted=1 two cycles after the transfer.
- Program "[+]" with cell=0: SKIP reaches depth 0; PC=3; tape unchanged; stack never written (o_stack_in=0 throughout).
- Program "++[->+<]": tape[0]=0, tape[1]=2; SP=0 at halt; o_error=00.
- Program "]" at PC 0: o_error=10 within 2 cycles; PC frozen at 0.
- STACK_AW=1, nested "+[[[": third push gives o_error=01.
- Tape preload 8'hFF, then '+': result 8'h00 without the macro, 8'hFF with BRAINHACK_CELL_SAT_EN. reset_n asserted during OUT drops o_out_valid asynchronously.

Source files
------------

// File: rtl/brainhack_defs.sv
// brainhack_defs: opcode, state and error encodings plus default widths
// shared by the brainhack execution core and its byte I/O port.
package brainhack_defs;

  localparam int DEF_TAPE_AW  = 8;
  localparam int DEF_TAPE_DW  = 8;
  localparam int DEF_PRG_AW   = 8;
  localparam int DEF_STACK_AW = 4;

  localparam logic [2:0] OP_INC   = 3'b000;
  localparam logic [2:0] OP_DEC   = 3'b001;
  localparam logic [2:0] OP_RIGHT = 3'b010;
  localparam logic [2:0] OP_LEFT  = 3'b011;
  localparam logic [2:0] OP_OUT   = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_LOOP  = 3'b110;
  localparam logic [2:0] OP_END   = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_OUT,
    ST_IN,
    ST_SKIP,
    ST_HALT,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
  localparam logic [1:0] ERR_UNMATCHED = 2'b11;

endpackage

// File: rtl/brainhack_io_port.sv
// brainhack_io_port: holding registers for the '.' (ready/valid out) and
// ',' (ready/valid in) byte handshakes. The core launches a transfer with a
// one-cycle start pulse; the port holds valid/ready until the partner accepts.
module brainhack_io_port
  import brainhack_defs::*;
#(
  parameter int DW = DEF_TAPE_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_out_start,
  input  logic [DW-1:0] i_out_byte,
  input  logic          i_in_start,
  input  logic          i_out_ready,
  input  logic          i_in_valid,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  output logic          o_in_ready,
  output logic          o_out_done,
  output logic          o_in_done
);

  logic          r_out_valid;
  logic          r_in_ready;
  logic [DW-1:0] r_out_data;

  assign o_out_done  = r_out_valid & i_out_ready;
  assign o_in_done   = r_in_ready & i_in_valid;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_in_ready  = r_in_ready;

  // Handshake flags: raised on launch, dropped on the accepting beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      if (i_out_start)
        r_out_valid <= 1'b1;
      else if (o_out_done)
        r_out_valid <= 1'b0;
      if (i_in_start)
        r_in_ready <= 1'b1;
      else if (o_in_done)
        r_in_ready <= 1'b0;
    end
  end

  // Output byte captured at launch so it stays stable while the sink stalls
  always_ff @(posedge clock) begin
    if (i_out_start)
      r_out_data <= i_out_byte;
  end

endmodule

// File: rtl/brainhack_core_p.sv
// brainhack_core_p: parametrised brainhack execution core. Fetches 3-bit
// opcodes from program ROM, works on tape RAM, keeps loop return addresses
// in stack RAM, skips zero-entry loops, halts at PRG_END and flags errors.
// Build option: define BRAINHACK_CELL_SAT_EN to make '+'/'-' saturate at
// all-ones/zero instead of wrapping.
module brainhack_core_p
  import brainhack_defs::*;
#(
  parameter int TAPE_AW  = DEF_TAPE_AW,
  parameter int TAPE_DW  = DEF_TAPE_DW,
  parameter int PRG_AW   = DEF_PRG_AW,
  parameter int STACK_AW = DEF_STACK_AW,
  parameter int PRG_END  = (1 << PRG_AW) - 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [TAPE_DW-1:0]  i_tape_data,
  input  logic [2:0]          i_prgmem_data,
  input  logic [PRG_AW-1:0]   i_stack_data,
  output logic                o_tape_in,
  output logic [TAPE_AW-1:0]  o_tape_addr,
  output logic [TAPE_DW-1:0]  o_tape_data,
  output logic [PRG_AW-1:0]   o_prgmem_addr,
  output logic                o_stack_in,
  output logic [STACK_AW-1:0] o_stack_addr,
  output logic [PRG_AW-1:0]   o_stack_data,
  output logic                o_out_valid,
  output logic [TAPE_DW-1:0]  o_out_data,
  input  logic                i_out_ready,
  input  logic                i_in_valid,
  input  logic [TAPE_DW-1:0]  i_in_data,
  output logic                o_in_ready,
  output logic                o_halted,
  output logic [1:0]          o_error
);

  localparam logic [PRG_AW-1:0] L_PRG_END = PRG_AW'(PRG_END);
  localparam logic [STACK_AW:0] L_SP_FULL = {1'b1, {STACK_AW{1'b0}}};

  state_t              r_state;
  logic [PRG_AW-1:0]   r_pc;
  logic [PRG_AW-1:0]   r_depth;
  logic [TAPE_AW-1:0]  r_tp;
  logic [STACK_AW:0]   r_sp;
  logic [2:0]          r_ir;
  logic [1:0]          r_err;

  logic                w_cell_zero;
  logic                w_cell_wr;
  logic [TAPE_DW-1:0]  w_cell_next;
  logic [PRG_AW-1:0]   w_pc_inc;
  logic [STACK_AW-1:0] w_sp_dec;
  logic                w_sp_empty;
  logic                w_sp_full;
  logic                w_at_end;
  logic                w_out_start;
  logic                w_in_start;
  logic                w_out_done;
  logic                w_in_done;

  // Returns {write_enable, new_value} for '+' (dec=0) or '-' (dec=1).
  // With saturation enabled the pinned cases suppress the write entirely.
  function automatic logic [TAPE_DW:0] cell_update(input logic [TAPE_DW-1:0] v,
                                                   input logic dec);
    logic [TAPE_DW-1:0] nxt;
    logic               wr;
    nxt = dec ? (v - TAPE_DW'(1)) : (v + TAPE_DW'(1));
`ifdef BRAINHACK_CELL_SAT_EN
    wr  = dec ? (v != '0) : (v != '1);
`else
    wr  = 1'b1;
`endif
    return {wr, nxt};
  endfunction

  assign {w_cell_wr, w_cell_next} = cell_update(i_tape_data, r_ir[0]);
  assign w_cell_zero = (i_tape_data == '0);
  assign w_pc_inc    = r_pc + PRG_AW'(1);
  assign w_sp_dec    = r_sp[STACK_AW-1:0] - STACK_AW'(1);
  assign w_sp_empty  = (r_sp == '0);
  assign w_sp_full   = (r_sp == L_SP_FULL);
  assign w_at_end    = (r_pc == L_PRG_END);

  assign o_tape_addr   = r_tp;
  assign o_prgmem_addr = r_pc;
  assign o_stack_data  = w_pc_inc;
  assign o_halted      = (r_state == ST_HALT);
  assign o_error       = r_err;

  brainhack_io_port #(
    .DW (TAPE_DW)
  ) u_io_port (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_out_start (w_out_start),
    .i_out_byte  (i_tape_data),
    .i_in_start  (w_in_start),
    .i_out_ready (i_out_ready),
    .i_in_valid  (i_in_valid),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_in_ready  (o_in_ready),
    .o_out_done  (w_out_done),
    .o_in_done   (w_in_done)
  );

  // Memory strobes and handshake launches decoded from state and opcode
  always_comb begin
    o_tape_in    = 1'b0;
    o_tape_data  = w_cell_next;
    o_stack_in   = 1'b0;
    o_stack_addr = w_sp_dec;
    w_out_start  = 1'b0;
    w_in_start   = 1'b0;
    case (r_state)
      ST_EXEC: begin
        case (r_ir)
          OP_INC, OP_DEC: o_tape_in = w_cell_wr;
          OP_OUT:         w_out_start = 1'b1;
          OP_IN:          w_in_start = 1'b1;
          OP_LOOP: begin
            if (!w_cell_zero && !w_sp_full) begin
              o_stack_in   = 1'b1;
              o_stack_addr = r_sp[STACK_AW-1:0];
            end
          end
          default: ;
        endcase
      end
      ST_IN: begin
        o_tape_data = i_in_data;
        o_tape_in   = w_in_done;
      end
      default: ;
    endcase
  end

  // Control FSM: fetch/execute, I/O waits, loop skip, halt and error traps
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_tp    <= '0;
      r_sp    <= '0;
      r_ir    <= '0;
      r_depth <= '0;
      r_err   <= ERR_NONE;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_at_end) begin
            r_state <= ST_HALT;
          end else begin
            r_ir    <= i_prgmem_data;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (r_ir)
            OP_INC, OP_DEC: r_pc <= w_pc_inc;
            OP_RIGHT: begin
              r_tp <= r_tp + TAPE_AW'(1);
              r_pc <= w_pc_inc;
            end
            OP_LEFT: begin
              r_tp <= r_tp - TAPE_AW'(1);
              r_pc <= w_pc_inc;
            end
            OP_OUT: r_state <= ST_OUT;
            OP_IN:  r_state <= ST_IN;
            OP_LOOP: begin
              if (w_cell_zero) begin
                r_depth <= PRG_AW'(1);
                r_pc    <= w_pc_inc;
                r_state <= ST_SKIP;
              end else if (w_sp_full) begin
                r_err   <= ERR_OVERFLOW;
                r_state <= ST_ERROR;
              end else begin
                r_sp <= r_sp + (STACK_AW+1)'(1);
                r_pc <= w_pc_inc;
              end
            end
            OP_END: begin
              if (w_sp_empty) begin
                r_err   <= ERR_UNDERFLOW;
                r_state <= ST_ERROR;
              end else if (!w_cell_zero) begin
                r_pc <= i_stack_data;
              end else begin
                r_sp <= r_sp - (STACK_AW+1)'(1);
                r_pc <= w_pc_inc;
              end
            end
          endcase
        end
        ST_OUT: begin
          if (w_out_done) begin
            r_pc    <= w_pc_inc;
            r_state <= ST_FETCH;
          end
        end
        ST_IN: begin
          if (w_in_done) begin
            r_pc    <= w_pc_inc;
            r_state <= ST_FETCH;
          end
        end
        ST_SKIP: begin
          if (w_at_end) begin
            r_err   <= ERR_UNMATCHED;
            r_state <= ST_ERROR;
          end else begin
            r_pc <= w_pc_inc;
            if (i_prgmem_data == OP_LOOP) begin
              r_depth <= r_depth + PRG_AW'(1);
            end else if (i_prgmem_data == OP_END) begin
              r_depth <= r_depth - PRG_AW'(1);
              if (r_depth == PRG_AW'(1))
                r_state <= ST_FETCH;
            end
          end
        end
        ST_HALT, ST_ERROR: ;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_brainhack_core_p.sv
// tb_brainhack_core_p: directed, table-driven bench for brainhack_core_p.
// The DUT runs with a 16-cell tape, 16-word program space halting at PC 8,
// and a two-entry loop stack. Program ROM, tape and stack RAMs are modelled
// here.
module tb_brainhack_core_p;

  localparam int TAPE_AW  = 4;
  localparam int TAPE_DW  = 8;
  localparam int PRG_AW   = 4;
  localparam int STACK_AW = 1;
  localparam int PRG_END  = 8;
`ifdef BRAINHACK_CELL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset_n = 1'b1;
  logic [TAPE_DW-1:0]  i_tape_data;
  logic [2:0]          i_prgmem_data;
  logic [PRG_AW-1:0]   i_stack_data;
  logic                o_tape_in;
  logic [TAPE_AW-1:0]  o_tape_addr;
  logic [TAPE_DW-1:0]  o_tape_data;
  logic [PRG_AW-1:0]   o_prgmem_addr;
  logic                o_stack_in;
  logic [STACK_AW-1:0] o_stack_addr;
  logic [PRG_AW-1:0]   o_stack_data;
  logic                o_out_valid;
  logic [TAPE_DW-1:0]  o_out_data;
  logic                i_out_ready = 1'b1;
  logic                i_in_valid = 1'b0;
  logic [TAPE_DW-1:0]  i_in_data = '0;
  logic                o_in_ready;
  logic                o_halted;
  logic [1:0]          o_error;

  logic [TAPE_DW-1:0] tape [16];
  logic [2:0]         rom  [16];
  logic [PRG_AW-1:0]  stk  [2];
  logic               pl_we = 1'b0;
  logic [7:0]         pl_t0 = '0;
  logic [7:0]         pl_t1 = '0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  brainhack_core_p #(
    .TAPE_AW  (TAPE_AW),
    .TAPE_DW  (TAPE_DW),
    .PRG_AW   (PRG_AW),
    .STACK_AW (STACK_AW),
    .PRG_END  (PRG_END)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_tape_data   (i_tape_data),
    .i_prgmem_data (i_prgmem_data),
    .i_stack_data  (i_stack_data),
    .o_tape_in     (o_tape_in),
    .o_tape_addr   (o_tape_addr),
    .o_tape_data   (o_tape_data),
    .o_prgmem_addr (o_prgmem_addr),
    .o_stack_in    (o_stack_in),
    .o_stack_addr  (o_stack_addr),
    .o_stack_data  (o_stack_data),
    .o_out_valid   (o_out_valid),
    .o_out_data    (o_out_data),
    .i_out_ready   (i_out_ready),
    .i_in_valid    (i_in_valid),
    .i_in_data     (i_in_data),
    .o_in_ready    (o_in_ready),
    .o_halted      (o_halted),
    .o_error       (o_error)
  );

  assign i_tape_data   = tape[o_tape_addr];
  assign i_prgmem_data = rom[o_prgmem_addr];
  assign i_stack_data  = stk[o_stack_addr];

  // Tape and stack RAMs; the preload strobe clears the tape and sets cells 0/1
  always @(posedge clock) begin
    if (pl_we) begin
      for (int i = 0; i < 16; i++) tape[i] <= 8'h00;
      tape[0] <= pl_t0;
      tape[1] <= pl_t1;
    end else if (o_tape_in) begin
      tape[o_tape_addr] <= o_tape_data;
    end
    if (o_stack_in) stk[o_stack_addr] <= o_stack_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] enc(input string s);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (s[i])
        "+": r[3*i +: 3] = 3'd0;
        "-": r[3*i +: 3] = 3'd1;
        ">": r[3*i +: 3] = 3'd2;
        "<": r[3*i +: 3] = 3'd3;
        ".": r[3*i +: 3] = 3'd4;
        ",": r[3*i +: 3] = 3'd5;
        "[": r[3*i +: 3] = 3'd6;
        default: r[3*i +: 3] = 3'd7;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string p, input logic [7:0] t0, input logic [7:0] t1);
    logic [23:0] code;
    reset_n     = 1'b0;
    i_out_ready = 1'b1;
    i_in_valid  = 1'b1;
    code = enc(p);
    for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? code[3*i +: 3] : 3'd0;
    pl_t0 = t0;
    pl_t1 = t1;
    pl_we = 1'b1;
    tick();
    pl_we = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    string      prog;
    logic [7:0] in_byte;
    logic [7:0] t0_pre;
    logic [7:0] t1_pre;
    logic [7:0] exp_t0;
    logic [7:0] exp_t1;
    logic       has_out;
    logic [7:0] exp_out;
    logic [1:0] exp_err;
    logic       exp_halt;
    logic [3:0] exp_pc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          cyc;
    logic        out_seen;
    logic [7:0]  out_byte;
    logic        st_seen;

    vecs[0] = '{"loop_move",   "++[->+<]", 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0, 8'h00, 2'b00, 1'b1, 4'd8};
    vecs[1] = '{"cell_bounds", "+>-<><><", 8'h00, 8'hFF, 8'h00,
                SAT ? 8'hFF : 8'h00, SAT ? 8'h00 : 8'hFF, 1'b0, 8'h00, 2'b00, 1'b1, 4'd8};
    vecs[2] = '{"overflow",    "+[[[><><", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 8'h00, 2'b01, 1'b0, 4'd3};
    vecs[3] = '{"underflow",   "]>>>>>>>", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b10, 1'b0, 4'd0};
    vecs[4] = '{"skip_simple", "[+]>+<><", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00, 2'b00, 1'b1, 4'd8};
    vecs[5] = '{"skip_nested", "[[]]>+<<", 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00, 2'b00, 1'b1, 4'd8};
    vecs[6] = '{"unmatched",   "[+++++++", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 2'b11, 1'b0, 4'd8};
    vecs[7] = '{"echo",        ",.><><><", 8'h5A, 8'h00, 8'h00, 8'h5A, 8'h00, 1'b1, 8'h5A, 2'b00, 1'b1, 4'd8};
    vecs[8] = '{"tp_wrap",     "+<+>+<+.", 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 1'b1, 8'h02, 2'b00, 1'b1, 4'd8};
    vecs[9] = '{"clear_loop",  "[-]>+<><", 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 1'b0, 8'h00, 2'b00, 1'b1, 4'd8};

    // Asynchronous reset values, before any clock edge
    for (int i = 0; i < 16; i++) rom[i] = 3'd0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_halted", {31'd0, o_halted}, 32'd0);
    chk("rst_error", {30'd0, o_error}, 32'd0);
    chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, o_in_ready}, 32'd0);
    chk("rst_pc", {28'd0, o_prgmem_addr}, 32'd0);
    chk("rst_tp", {28'd0, o_tape_addr}, 32'd0);
    chk("rst_tape_in", {31'd0, o_tape_in}, 32'd0);
    chk("rst_stack_in", {31'd0, o_stack_in}, 32'd0);

    // Table: run each program to halt or error with free-flowing I/O
    for (int v = 0; v < 10; v++) begin
      do_reset(vecs[v].prog, vecs[v].t0_pre, vecs[v].t1_pre);
      i_in_data = vecs[v].in_byte;
      cyc = 0;
      out_seen = 1'b0;
      out_byte = '0;
      while (!(o_halted || o_error != 2'b00) && cyc < 300) begin
        tick();
        cyc++;
        if (o_out_valid) begin
          out_seen = 1'b1;
          out_byte = o_out_data;
        end
      end
      if (cyc >= 300) begin
        n_checks++;
        n_err++;
        $display("FAIL %s_timeout: no halt/error after %0d cycles", vecs[v].name, cyc);
      end
      chk({vecs[v].name, "_halted"}, {31'd0, o_halted}, {31'd0, vecs[v].exp_halt});
      chk({vecs[v].name, "_error"}, {30'd0, o_error}, {30'd0, vecs[v].exp_err});
      chk({vecs[v].name, "_pc"}, {28'd0, o_prgmem_addr}, {28'd0, vecs[v].exp_pc});
      chk({vecs[v].name, "_tape0"}, {24'd0, tape[0]}, {24'd0, vecs[v].exp_t0});
      chk({vecs[v].name, "_tape1"}, {24'd0, tape[1]}, {24'd0, vecs[v].exp_t1});
      chk({vecs[v].name, "_out_seen"}, {31'd0, out_seen}, {31'd0, vecs[v].has_out});
      if (vecs[v].has_out)
        chk({vecs[v].name, "_out_data"}, {24'd0, out_byte}, {24'd0, vecs[v].exp_out});
    end

    // Output held stable under back-pressure, halt after the transfer
    do_reset("><><+++.", 8'h00, 8'h00);
    i_out_ready = 1'b0;
    cyc = 0;
    while (!o_out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("out_reach", {31'd0, o_out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("out_hold_valid", {31'd0, o_out_valid}, 32'd1);
      chk("out_hold_data", {24'd0, o_out_data}, 32'd3);
      chk("out_hold_pc", {28'd0, o_prgmem_addr}, 32'd7);
      tick();
    end
    i_out_ready = 1'b1;
    tick();
    chk("out_done_valid", {31'd0, o_out_valid}, 32'd0);
    chk("out_done_halted", {31'd0, o_halted}, 32'd0);
    chk("out_done_pc", {28'd0, o_prgmem_addr}, 32'd8);
    tick();
    chk("out_halted", {31'd0, o_halted}, 32'd1);
    chk("out_tape0", {24'd0, tape[0]}, 32'd3);

    // Reset asserted mid-cycle during OUT drops valid without a clock edge
    do_reset("><><+++.", 8'h00, 8'h00);
    i_out_ready = 1'b0;
    cyc = 0;
    while (!o_out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("arst_reach", {31'd0, o_out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_out_valid}, 32'd0);
    chk("arst_pc", {28'd0, o_prgmem_addr}, 32'd0);
    chk("arst_tp", {28'd0, o_tape_addr}, 32'd0);

    // Zero-entry loop skip timing and no stack/tape traffic
    do_reset("[+]>+<><", 8'h00, 8'h00);
    st_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_stack_in || o_tape_in) st_seen = 1'b1;
    end
    chk("skip_pc3", {28'd0, o_prgmem_addr}, 32'd3);
    chk("skip_no_writes", {31'd0, st_seen}, 32'd0);
    chk("skip_tape0", {24'd0, tape[0]}, 32'd0);
    cyc = 0;
    while (!o_halted && cyc < 60) begin
      tick();
      cyc++;
      if (o_stack_in) st_seen = 1'b1;
    end
    chk("skip_halted", {31'd0, o_halted}, 32'd1);
    chk("skip_no_push", {31'd0, st_seen}, 32'd0);

    // Underflow reported two cycles after reset, then frozen
    do_reset("]>>>>>>>", 8'h00, 8'h00);
    tick();
    chk("uf_early", {30'd0, o_error}, 32'd0);
    tick();
    chk("uf_error", {30'd0, o_error}, 32'd2);
    chk("uf_pc", {28'd0, o_prgmem_addr}, 32'd0);
    for (int k = 0; k < 3; k++) tick();
    chk("uf_error_hold", {30'd0, o_error}, 32'd2);
    chk("uf_pc_hold", {28'd0, o_prgmem_addr}, 32'd0);
    chk("uf_not_halted", {31'd0, o_halted}, 32'd0);

    // Input handshake waits for a late valid
    do_reset(",.><><><", 8'h00, 8'h00);
    i_in_valid = 1'b0;
    tick();
    tick();
    chk("in_ready", {31'd0, o_in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) tick();
    chk("in_ready_hold", {31'd0, o_in_ready}, 32'd1);
    chk("in_pc_hold", {28'd0, o_prgmem_addr}, 32'd0);
    i_in_data  = 8'h3C;
    i_in_valid = 1'b1;
    tick();
    chk("in_ready_drop", {31'd0, o_in_ready}, 32'd0);
    chk("in_tape0", {24'd0, tape[0]}, 32'h3C);
    chk("in_pc", {28'd0, o_prgmem_addr}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
